// File: rtl/multicycle_main_fsm_pkg.sv
// Shared control encodings for the multicycle main FSM: state enum, mux-select
// constants, opcode constants and the packed control vector.
`timescale 1ns/1ps
package multicycle_main_fsm_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_EXECUTER = 4'd7,
    S_EXECUTEI = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  localparam logic [1:0] SRCA_REG   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP      = 2'b00;
  localparam logic [1:0] OP_MEM     = 2'b01;
  localparam logic [1:0] OP_BR      = 2'b10;
  localparam logic [1:0] OP_UNDEF   = 2'b11;

  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       undef;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the main FSM (master) and the datapath (slave).
`timescale 1ns/1ps
interface multicycle_main_fsm_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic       mem_ready;
  logic       ir_write;
  logic       next_pc;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       alu_op;
  logic       reg_w;
  logic       mem_w;
  logic       branch;
  logic       undef;
  logic       instr_done;
  logic [3:0] state;

  modport master (
    input  op, funct, mem_ready,
    output ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src,
           alu_op, reg_w, mem_w, branch, undef, instr_done, state
  );

  modport slave (
    output op, funct, mem_ready,
    input  ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src,
           alu_op, reg_w, mem_w, branch, undef, instr_done, state
  );
endinterface

// File: rtl/main_fsm_out_decode.sv
// Moore output decoder: state (plus mem_ready in wait states, op in DECODE)
// to control vector. Illegal encodings decode to all zeros.
`timescale 1ns/1ps
module main_fsm_out_decode
  import multicycle_main_fsm_pkg::*;
(
  input  state_t     state,
  input  logic [1:0] op,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ready;
        ctrl.next_pc    = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        ctrl.undef      = (op == OP_UNDEF);
        ctrl.instr_done = (op == OP_UNDEF);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: ctrl.adr_src = 1'b1;
      S_MEMWB: begin
        ctrl.result_src = RES_RDATA;
        ctrl.reg_w      = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      // mem_w stays high through every wait cycle until the store completes
      S_MEMWR: begin
        ctrl.adr_src    = 1'b1;
        ctrl.mem_w      = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXECUTER: begin
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = 1'b1;
      end
      S_EXECUTEI: begin
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = 1'b1;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_w      = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_REG;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALU;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle datapath: state register and next-state
// logic; outputs are decoded combinationally from the state.
`timescale 1ns/1ps
module multicycle_main_fsm
  import multicycle_main_fsm_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  multicycle_main_fsm_if.master  bus
);

  state_t state_q;
  ctrl_t  ctrl;
  logic   unused_funct;

  assign unused_funct = ^bus.funct[4:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
    end else begin
      case (state_q)
        S_RESET:  state_q <= S_FETCH;
        S_FETCH:  state_q <= bus.mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (bus.op)
            OP_MEM:  state_q <= S_MEMADR;
            OP_DP:   state_q <= bus.funct[5] ? S_EXECUTEI : S_EXECUTER;
            OP_BR:   state_q <= S_BRANCH;
            default: state_q <= S_FETCH;
          endcase
        end
        S_MEMADR:   state_q <= bus.funct[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:    state_q <= bus.mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWR:    state_q <= bus.mem_ready ? S_FETCH : S_MEMWR;
        S_MEMWB:    state_q <= S_FETCH;
        S_EXECUTER: state_q <= S_ALUWB;
        S_EXECUTEI: state_q <= S_ALUWB;
        S_ALUWB:    state_q <= S_FETCH;
        S_BRANCH:   state_q <= S_FETCH;
        default:    state_q <= S_RESET;
      endcase
    end
  end

  main_fsm_out_decode u_out_decode (
    .state     (state_q),
    .op        (bus.op),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.ir_write   = ctrl.ir_write;
  assign bus.next_pc    = ctrl.next_pc;
  assign bus.adr_src    = ctrl.adr_src;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.result_src = ctrl.result_src;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.reg_w      = ctrl.reg_w;
  assign bus.mem_w      = ctrl.mem_w;
  assign bus.branch     = ctrl.branch;
  assign bus.undef      = ctrl.undef;
  assign bus.instr_done = ctrl.instr_done;
  assign bus.state      = state_q;

endmodule

// File: doc/multicycle_main_fsm.md
# multicycle_main_fsm

Main control state machine for the multicycle datapath. It sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives the datapath mux selects, and produces the unconditional write/branch requests consumed directly downstream by the conditional-execution logic (`pcs`, `reg_w`, `mem_w`). Outputs are Moore outputs: a pure function of the state, plus `mem_ready` in memory-wait states.

## Interface
- No parameters. Encodings are fixed in the shared package.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `op`  in  2  instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- `funct`  in  6  instr[25:20]. Bit 5 is I (immediate operand); bit 0 is L (load) for memory ops and S for data-processing.
- `mem_ready`  in  1  memory has completed the current access this cycle.
- `ir_write`  out  1  load the instruction register.
- `next_pc`  out  1  unconditional PC update (PC+4).
- `adr_src`  out  1  address mux select: 0 = PC, 1 = ALU result register.
- `alu_src_a`  out  2  00 = reg A, 01 = PC.
- `alu_src_b`  out  2  00 = reg B/shifted, 01 = extended immediate, 10 = constant 4.
- `result_src`  out  2  00 = ALU result register, 01 = read data register, 10 = ALU direct.
- `alu_op`  out  1  1 = ALU decoder uses funct (flag writes permitted); 0 = forced ADD, no flags.
- `reg_w`  out  1  register writeback request; gated downstream by condition.
- `mem_w`  out  1  memory write request; gated downstream by condition.
- `branch`  out  1  branch request; feeds `pcs` downstream.
- `undef`  out  1  one-cycle pulse when an op=11 instruction is decoded.
- `instr_done`  out  1  one-cycle pulse on the final cycle of every instruction.
- `state`  out  4  current state encoding, for debug and verification.

## Operation
- States: RESET, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Asserted outputs per state. Any output not listed is 0.
  - RESET: none.
  - FETCH: adr_src=0, alu_src_a=01, alu_src_b=10, result_src=10, ir_write=mem_ready, next_pc=mem_ready.
  - DECODE: alu_src_a=01, alu_src_b=10, result_src=10.
  - MEMADR: alu_src_a=00, alu_src_b=01.
  - MEMRD: adr_src=1.
  - MEMWB: result_src=01, reg_w=1.
  - MEMWR: adr_src=1, mem_w=1. `mem_w` is held until `mem_ready` is seen.
  - EXECUTER: alu_src_b=00, alu_op=1.
  - EXECUTEI: alu_src_b=01, alu_op=1.
  - ALUWB: result_src=00, reg_w=1.
  - BRANCH: alu_src_a=00, alu_src_b=01, result_src=10, branch=1.
- Transitions:
  - RESET→FETCH.
  - FETCH→DECODE when mem_ready=1; otherwise stays in FETCH.
  - DECODE decides on `op`:
    - op=01→MEMADR.
    - op=00: funct[5]=0→EXECUTER, funct[5]=1→EXECUTEI.
    - op=10→BRANCH.
    - op=11→FETCH, with undef=1 in that DECODE cycle.
  - MEMADR: funct[0]=1→MEMRD, funct[0]=0→MEMWR.
  - MEMRD: mem_ready=1→MEMWB; otherwise stays.
  - MEMWR: mem_ready=1→FETCH; otherwise stays.
  - MEMWB, ALUWB and BRANCH→FETCH.
  - EXECUTER and EXECUTEI→ALUWB.
- `instr_done`=1 in these cycles: MEMWB; ALUWB; BRANCH; MEMWR when mem_ready=1; DECODE when op=11.
- `op` and `funct` are sampled only in DECODE and MEMADR, where they come from the stable IR. In all other states they are don't-care.
- An illegal state encoding goes to RESET on the next edge, with all outputs 0 in that cycle.

## Timing
- Reset: asynchronous entry to RESET. While reset is low, every output is 0 and `state` = RESET encoding.
- After reset is released, the first rising edge goes to FETCH, so the first instruction fetch is exactly one cycle after release.
- Latency in cycles, with `mem_ready` constantly 1:
  - data-processing: 4
  - branch: 3
  - store: 4
  - load: 5
  - undefined: 2
- Each wait cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- In FETCH, `ir_write` and `next_pc` are asserted only in the cycle in which mem_ready=1, so the PC advances exactly once per fetch.
- Reset asserted mid-instruction aborts the instruction immediately; no partial `reg_w`/`mem_w` is driven after the asserting edge.
- Outputs settle combinationally from the state register (plus `mem_ready`). There is no output register.

## Structure
- Shared control package holds:
  - the state enum typedef (4-bit, explicit encodings: RESET=0, FETCH=1 … BRANCH=10);
  - named constants for the `alu_src_a`, `alu_src_b` and `result_src` encodings;
  - the op constants OP_DP, OP_MEM, OP_BR.
- One sub-module is natural: `main_fsm_out_decode`, a combinational state(+mem_ready)→control-vector decoder. The state register and next-state logic stay in the top.

## Test plan
- Reset low for 3 cycles, then released: all outputs 0 and state=0 during reset; state=1 (FETCH) one cycle after release.
- op=00, funct=6'b000000 (ADD register), mem_ready=1: state sequence 1,2,7,9,1; alu_op=1 only in state 7; reg_w=1 only in state 9; instr_done pulses in state 9.
- op=01, funct=6'b011001 (LDR imm): states 1,2,3,4,5; mem_ready held 0 for 2 cycles in MEMRD, giving 2 extra MEMRD cycles; result_src=01 and reg_w=1 in MEMWB.
- op=01, funct=6'b011000 (STR): mem_w=1 for every MEMWR cycle, including 3 wait cycles; next state FETCH immediately after mem_ready=1.
- op=10: BRANCH has branch=1, alu_src_b=01, result_src=10, then FETCH. Separately, op=11: undef=1 and instr_done=1 in DECODE, then FETCH.
- FETCH with mem_ready=0 for 4 cycles, then 1: next_pc and ir_write asserted in exactly one cycle. Reset pulsed in EXECUTER: state 0 immediately, and reg_w never asserted.
